rng_insert_mc: RTL and testbench

- Multi-channel stochastic-bitstream probability corrector.
- Per channel, forces output ones/zeros so every window of W = 2^iWinLog2 bits carries exactly T = floor(p*W) ones, where p = iProb/2^FBITWIDTH.
- Input bits pass unchanged wherever the target still allows it.
- Mode 0 is endpoint-only (greedy). Mode 1 additionally keeps the running ones count within ±TOL of the ideal ramp, spreading the inserted bits through the window.
- Sits between SNG/RNG sources and stochastic arithmetic, where it corrects bias per window.

---
 rtl/rng_insert_pkg.sv | 19 +
 rtl/rng_insert_lane.sv | 105 ++++++++++
 rtl/rng_insert_mc.sv | 93 +++++++++
 tb/tb_rng_insert_mc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rng_insert_pkg.sv
// Shared constants and helpers for the stochastic-bitstream window corrector.
package rng_insert_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_SPREAD = 1'b1;

  // Accumulator must hold W * max(prob) without overflow.
  function automatic int unsigned acc_width(input int unsigned bw, input int unsigned fw);
    return bw + fw;
  endfunction

  // Ones target for one window: floor(prob * 2^winlog2 / 2^fbw).
  function automatic logic [31:0] calc_target(input logic [31:0] prob,
                                              input logic [31:0] winlog2,
                                              input int unsigned fbw);
    return (prob << winlog2) >> fbw;
  endfunction

endpackage

// File: rtl/rng_insert_lane.sv
// One channel: latched target, ones count, ramp accumulator and output decision.
module rng_insert_lane
  import rng_insert_pkg::*;
#(
  parameter int unsigned BITWIDTH     = 8,
  parameter int unsigned BITWIDTHLOG2 = 3,
  parameter int unsigned FBITWIDTH    = 8,
  parameter int unsigned TOL          = 0
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iClr,
  input  logic                    iEn,
  input  logic                    iWinStart,
  input  logic                    iLast,
  input  logic                    iMode,
  input  logic [BITWIDTHLOG2-1:0] iWinLog2,
  input  logic [BITWIDTH-1:0]     iRemain,
  input  logic [FBITWIDTH-1:0]    iProb,
  input  logic                    iA,
  output logic                    oOut,
  output logic                    oForced
);

  localparam int unsigned AW = acc_width(BITWIDTH, FBITWIDTH);
  localparam int unsigned CW = BITWIDTH + 2;

  logic [BITWIDTH-1:0]  t_q, t_d, e_q, e_d;
  logic [FBITWIDTH-1:0] prob_q, prob_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic                 out_q, out_d, forced_q, forced_d;

  logic [BITWIDTH-1:0]  t_c;
  logic [FBITWIDTH-1:0] prob_c;
  logic [AW-1:0]        acc_nxt_c;
  logic [CW-1:0]        ideal_c, eb_c;
  logic                 bit_c;

  // Window-start cycle uses the live inputs; later cycles use the latched copy.
  always_comb begin
    t_c       = iWinStart ? BITWIDTH'(calc_target(32'(iProb), 32'(iWinLog2), FBITWIDTH)) : t_q;
    prob_c    = iWinStart ? iProb : prob_q;
    acc_nxt_c = acc_q + AW'(prob_c);
    ideal_c   = CW'(acc_nxt_c >> FBITWIDTH);
    eb_c      = CW'(e_q) + CW'(iA);
    if (e_q == t_c) begin
      bit_c = 1'b0;
    end else if ((t_c - e_q) == iRemain) begin
      bit_c = 1'b1;
    end else if ((iMode == MODE_SPREAD) && (eb_c > (ideal_c + CW'(TOL)))) begin
      bit_c = 1'b0;
    end else if ((iMode == MODE_SPREAD) && ((eb_c + CW'(TOL)) < ideal_c)) begin
      bit_c = 1'b1;
    end else begin
      bit_c = iA;
    end
  end

  always_comb begin
    t_d      = t_q;
    prob_d   = prob_q;
    e_d      = e_q;
    acc_d    = acc_q;
    out_d    = 1'b0;
    forced_d = 1'b0;
    if (iClr) begin
      e_d   = '0;
      acc_d = '0;
    end else if (iEn) begin
      t_d      = t_c;
      prob_d   = prob_c;
      out_d    = bit_c;
      forced_d = bit_c ^ iA;
      if (iLast) begin
        e_d   = '0;
        acc_d = '0;
      end else begin
        e_d   = e_q + BITWIDTH'(bit_c);
        acc_d = acc_nxt_c;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      t_q      <= '0;
      prob_q   <= '0;
      e_q      <= '0;
      acc_q    <= '0;
      out_q    <= 1'b0;
      forced_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      prob_q   <= prob_d;
      e_q      <= e_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      forced_q <= forced_d;
    end
  end

  assign oOut    = out_q;
  assign oForced = forced_q;

endmodule

// File: rtl/rng_insert_mc.sv
// Multi-channel window corrector: shared window counter plus NCH independent lanes.
module rng_insert_mc
  import rng_insert_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned BITWIDTH     = 8,
  parameter int unsigned BITWIDTHLOG2 = 3,
  parameter int unsigned FBITWIDTH    = 8,
  parameter int unsigned TOL          = 0
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iClr,
  input  logic                     iEn,
  input  logic                     iMode,
  input  logic [BITWIDTHLOG2-1:0]  iWinLog2,
  input  logic [NCH*FBITWIDTH-1:0] iProb,
  input  logic [NCH-1:0]           iA,
  output logic [NCH-1:0]           oOut,
  output logic [NCH-1:0]           oForced,
  output logic                     oWinDone
);

  logic [BITWIDTH-1:0] i_q, i_d, w_q, w_d;
  logic                mode_q, mode_d, done_q, done_d;

  logic                win_start_c, last_c, mode_c;
  logic [BITWIDTH-1:0] w_c, remain_c;

  // Window length and mode come from the live inputs only on bit 0.
  always_comb begin
    win_start_c = (i_q == '0);
    w_c         = win_start_c ? (BITWIDTH'(1) << iWinLog2) : w_q;
    mode_c      = win_start_c ? iMode : mode_q;
    last_c      = (i_q == (w_c - BITWIDTH'(1)));
    remain_c    = w_c - i_q;
  end

  always_comb begin
    i_d    = i_q;
    w_d    = w_q;
    mode_d = mode_q;
    done_d = 1'b0;
    if (iClr) begin
      i_d = '0;
    end else if (iEn) begin
      w_d    = w_c;
      mode_d = mode_c;
      i_d    = last_c ? '0 : (i_q + BITWIDTH'(1));
      done_d = last_c;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      i_q    <= '0;
      w_q    <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      i_q    <= i_d;
      w_q    <= w_d;
      mode_q <= mode_d;
      done_q <= done_d;
    end
  end

  assign oWinDone = done_q;

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    rng_insert_lane #(
      .BITWIDTH    (BITWIDTH),
      .BITWIDTHLOG2(BITWIDTHLOG2),
      .FBITWIDTH   (FBITWIDTH),
      .TOL         (TOL)
    ) u_lane (
      .iClk     (iClk),
      .iRstN    (iRstN),
      .iClr     (iClr),
      .iEn      (iEn),
      .iWinStart(win_start_c),
      .iLast    (last_c),
      .iMode    (mode_c),
      .iWinLog2 (iWinLog2),
      .iRemain  (remain_c),
      .iProb    (iProb[g*FBITWIDTH +: FBITWIDTH]),
      .iA       (iA[g]),
      .oOut     (oOut[g]),
      .oForced  (oForced[g])
    );
  end

endmodule

// File: tb/tb_rng_insert_mc.sv
// Directed bench for rng_insert_mc: window targets, spreading, disturbances, reset.
module tb_rng_insert_mc;

  localparam int unsigned NCH = 4;

  logic           iClk = 1'b0;
  logic           iRstN;
  logic           iClr;
  logic           iEn;
  logic           iMode;
  logic [2:0]     iWinLog2;
  logic [31:0]    iProb;
  logic [NCH-1:0] iA;
  logic [NCH-1:0] oOut;
  logic [NCH-1:0] oForced;
  logic           oWinDone;

  int total = 0;
  int bad   = 0;

  rng_insert_mc #(
    .NCH(4), .BITWIDTH(8), .BITWIDTHLOG2(3), .FBITWIDTH(8), .TOL(0)
  ) dut (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iClr    (iClr),
    .iEn     (iEn),
    .iMode   (iMode),
    .iWinLog2(iWinLog2),
    .iProb   (iProb),
    .iA      (iA),
    .oOut    (oOut),
    .oForced (oForced),
    .oWinDone(oWinDone)
  );

  always #5 iClk = ~iClk;

  task automatic step(input logic en, input logic clr, input logic [NCH-1:0] a);
    iEn = en; iClr = clr; iA = a;
    @(posedge iClk); #1;
  endtask

  task automatic test_reset;
    iRstN = 1'b0; iClr = 1'b0; iEn = 1'b0; iMode = 1'b0;
    iWinLog2 = 3'd0; iProb = '0; iA = '0;
    repeat (3) @(posedge iClk);
    #1;
    total++; if (oOut !== 4'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", oOut); end
    total++; if (oForced !== 4'h0) begin bad++; $display("FAIL reset_forced got=%h exp=0", oForced); end
    total++; if (oWinDone !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", oWinDone); end
    @(negedge iClk); iRstN = 1'b1;
  endtask

  task automatic test_mode0_half;
    logic exp;
    iMode = 1'b0; iWinLog2 = 3'd4; iProb = {4{8'h80}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, 4'hF);
      exp = ((k % 16) < 8);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL half_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oForced !== {4{~exp}}) begin bad++; $display("FAIL half_forced k=%0d got=%h exp=%h", k, oForced, {4{~exp}}); end
      total++; if (oWinDone !== ((k % 16) == 15)) begin bad++; $display("FAIL half_done k=%0d got=%b", k, oWinDone); end
    end
  endtask

  task automatic test_mode0_quarter;
    logic exp;
    iMode = 1'b0; iWinLog2 = 3'd4; iProb = {4{8'h40}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'h0);
      exp = (k >= 12);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL quarter_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oForced !== {4{exp}}) begin bad++; $display("FAIL quarter_forced k=%0d got=%h exp=%h", k, oForced, {4{exp}}); end
    end
  endtask

  task automatic test_mode1_spread;
    logic exp;
    iMode = 1'b1; iWinLog2 = 3'd4; iProb = {4{8'h40}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0, 4'h0);
      exp = ((k % 4) == 3);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL spread_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oWinDone !== ((k % 16) == 15)) begin bad++; $display("FAIL spread_done k=%0d got=%b", k, oWinDone); end
    end
    iMode = 1'b0;
  endtask

  task automatic test_edges;
    logic exp;
    // p max, W=2 -> one 1 per window
    iWinLog2 = 3'd1; iProb = {4{8'hFF}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 4'hF);
      exp = ((k % 2) == 0);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL w2_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oWinDone !== ((k % 2) == 1)) begin bad++; $display("FAIL w2_done k=%0d got=%b", k, oWinDone); end
    end
    // p = 0 -> everything forced low
    iWinLog2 = 3'd4; iProb = '0;
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'hF);
      total++; if (oOut !== 4'h0) begin bad++; $display("FAIL p0_out k=%0d got=%h exp=0", k, oOut); end
      total++; if (oForced !== 4'hF) begin bad++; $display("FAIL p0_forced k=%0d got=%h exp=f", k, oForced); end
    end
    // W = 1 -> T = 0 and a window ends every bit
    iWinLog2 = 3'd0; iProb = {4{8'hFF}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 4'hF);
      total++; if (oOut !== 4'h0) begin bad++; $display("FAIL w1_out k=%0d got=%h exp=0", k, oOut); end
      total++; if (oWinDone !== 1'b1) begin bad++; $display("FAIL w1_done k=%0d got=%b exp=1", k, oWinDone); end
    end
  endtask

  task automatic test_disturb;
    int ones;
    logic exp;
    // Probability change mid-window only takes effect next window
    iMode = 1'b0; iWinLog2 = 3'd4; iProb = {4{8'h40}};
    step(1'b1, 1'b1, 4'h0);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) iProb = {4{8'hC0}};
      step(1'b1, 1'b0, 4'h0);
      ones += int'(oOut[0]);
    end
    total++; if (ones !== 4) begin bad++; $display("FAIL probchg_win1 got=%0d exp=4", ones); end
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'h0);
      ones += int'(oOut[0]);
      if (k == 15) begin
        total++; if (oWinDone !== 1'b1) begin bad++; $display("FAIL probchg_done got=%b exp=1", oWinDone); end
      end
    end
    total++; if (ones !== 12) begin bad++; $display("FAIL probchg_win2 got=%0d exp=12", ones); end

    // Enable gap of 3 cycles at bit 6
    iProb = {4{8'h80}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b0, 4'hF);
          total++; if ({oOut, oForced, oWinDone} !== 9'h0) begin bad++; $display("FAIL gap_outs g=%0d got=%h exp=0", g, {oOut, oForced, oWinDone}); end
        end
      end
      step(1'b1, 1'b0, 4'hF);
      exp = (k < 8);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL gap_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oWinDone !== (k == 15)) begin bad++; $display("FAIL gap_done k=%0d got=%b", k, oWinDone); end
    end

    // Clear at bit 9 restarts the window
    iProb = {4{8'h40}};
    step(1'b1, 1'b1, 4'h0);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'hF);
    total++; if ({oOut, oForced, oWinDone} !== 9'h0) begin bad++; $display("FAIL clr_outs got=%h exp=0", {oOut, oForced, oWinDone}); end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'h0);
      exp = (k >= 12);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL clr_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oWinDone !== (k == 15)) begin bad++; $display("FAIL clr_done k=%0d got=%b", k, oWinDone); end
    end
  endtask

  task automatic test_multi_channel;
    int ones [NCH];
    int exp_t [NCH];
    logic exp;
    exp_t[0] = 4; exp_t[1] = 12; exp_t[2] = 20; exp_t[3] = 28;
    iMode = 1'b0; iWinLog2 = 3'd5; iProb = {8'hE0, 8'hA0, 8'h60, 8'h20};
    step(1'b1, 1'b1, 4'h0);
    for (int c = 0; c < NCH; c++) ones[c] = 0;
    for (int k = 0; k < 64; k++) begin
      step(1'b1, 1'b0, 4'($urandom));
      for (int c = 0; c < NCH; c++) ones[c] += int'(oOut[c]);
      total++; if (oWinDone !== ((k % 32) == 31)) begin bad++; $display("FAIL multi_done k=%0d got=%b", k, oWinDone); end
      if ((k % 32) == 31) begin
        for (int c = 0; c < NCH; c++) begin
          total++; if (ones[c] !== exp_t[c]) begin bad++; $display("FAIL multi_ones ch=%0d got=%0d exp=%0d", c, ones[c], exp_t[c]); end
          ones[c] = 0;
        end
      end
    end

    // Async reset mid-window, then the first enabled bit is bit 0
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 4'hF);
    total++; if (oOut[3] !== 1'b1) begin bad++; $display("FAIL prerst_out got=%b exp=1", oOut[3]); end
    #3 iRstN = 1'b0;
    #1;
    total++; if ({oOut, oForced, oWinDone} !== 9'h0) begin bad++; $display("FAIL async_rst got=%h exp=0", {oOut, oForced, oWinDone}); end
    @(negedge iClk); iRstN = 1'b1;
    iWinLog2 = 3'd4; iProb = {4{8'h80}};
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0, 4'hF);
      exp = (k < 8);
      total++; if (oOut !== {4{exp}}) begin bad++; $display("FAIL postrst_out k=%0d got=%h exp=%h", k, oOut, {4{exp}}); end
      total++; if (oWinDone !== (k == 15)) begin bad++; $display("FAIL postrst_done k=%0d got=%b", k, oWinDone); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_half();
    test_mode0_quarter();
    test_mode1_spread();
    test_edges();
    test_disturb();
    test_multi_channel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
